fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, instruction field
// positions, reset vector default and the controller opcode/funct constants.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Instruction field positions (LSB and width) within the 32-bit IR.
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int REG_W      = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request, a single instruction
// register, redirect handling with a kill flag for a stale in-flight ack.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [31:0] pc_out
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  ir;
    logic         kill;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= align_word(RESET_VECTOR);
            ir     <= '0;
            pc_out <= '0;
            kill   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) pc <= align_word(redirect_pc);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (redirect) begin
                        // A request still in flight must have its ack dropped.
                        pc   <= align_word(redirect_pc);
                        kill <= !imem_ack;
                    end else if (imem_ack) begin
                        if (kill) begin
                            kill <= 1'b0;
                        end else begin
                            ir     <= imem_rdata;
                            pc_out <= pc;
                            pc     <= pc + 32'd4;
                            state  <= S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (redirect) begin
                        pc    <= align_word(redirect_pc);
                        state <= S_WAIT;
                    end else if (!stall) begin
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (state == S_WAIT);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_VALID);

    assign opcode = ir[OPCODE_LSB +: OPCODE_W];
    assign funct  = ir[FUNCT_LSB  +: FUNCT_W];
    assign rs     = ir[RS_LSB     +: REG_W];
    assign rt     = ir[RT_LSB     +: REG_W];
    assign rd     = ir[RD_LSB     +: REG_W];
    assign imm16  = ir[IMM_LSB    +: IMM_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// ack/stall/redirect traffic against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [31:0] pc_out;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "started" = has left the post-reset idle cycle,
    // "holding" = an instruction waits to be consumed, "stale" = the
    // outstanding memory response belongs to an abandoned address.
    bit          m_started;
    bit          m_holding;
    bit          m_stale;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pcout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_started = 0;
        m_holding = 0;
        m_stale   = 0;
        m_pc      = 32'h0000_0000;
        m_ir      = 32'h0;
        m_pcout   = 32'h0;
    endtask

    task automatic model_advance(input bit a, input logic [31:0] w, input bit st,
                                 input bit rdir, input logic [31:0] rpc);
        logic [31:0] target;
        target = rpc & 32'hFFFF_FFFC;
        if (!m_started) begin
            if (rdir) m_pc = target;
            m_started = 1;
        end else if (m_holding) begin
            if (rdir) begin
                m_pc = target;
                m_holding = 0;
            end else if (!st) begin
                m_holding = 0;
            end
        end else begin
            if (rdir) begin
                m_pc    = target;
                m_stale = !a;
            end else if (a) begin
                if (m_stale) begin
                    m_stale = 0;
                end else begin
                    m_ir      = w;
                    m_pcout   = m_pc;
                    m_pc      = m_pc + 32'd4;
                    m_holding = 1;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        bit exp_req;
        exp_req = m_started && !m_holding;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_holding});
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        if (m_holding) begin
            check("pc_out", pc_out, m_pcout);
            check("opcode", {26'b0, opcode}, {26'b0, m_ir[31:26]});
            check("funct",  {26'b0, funct},  {26'b0, m_ir[5:0]});
            check("rs",     {27'b0, rs},     {27'b0, m_ir[25:21]});
            check("rt",     {27'b0, rt},     {27'b0, m_ir[20:16]});
            check("rd",     {27'b0, rd},     {27'b0, m_ir[15:11]});
            check("imm16",  {16'b0, imm16},  {16'b0, m_ir[15:0]});
        end
    endtask

    // One clock cycle: check current outputs, apply inputs, advance both.
    task automatic step(input bit a, input logic [31:0] w, input bit st,
                        input bit rdir, input logic [31:0] rpc);
        compare_outputs();
        imem_ack    = a;
        imem_rdata  = w;
        stall       = st;
        redirect    = rdir;
        redirect_pc = rpc;
        model_advance(a, w, st, rdir, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_req",   {31'b0, imem_req}, 32'd0);
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_pc_out", pc_out, 32'd0);
        check("reset_opcode", {26'b0, opcode}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back fetches, ack one cycle after each request.
        idle_step();
        check("first_addr", imem_addr, 32'h0);
        step(1'b1, 32'h012A_4020, 1'b0, 1'b0, 32'h0);
        check("add_opcode", {26'b0, opcode}, 32'h00);
        check("add_funct",  {26'b0, funct},  32'h20);
        check("add_pc_out", pc_out, 32'h0);
        idle_step();
        check("second_addr", imem_addr, 32'h4);
        step(1'b1, 32'h0123_4567, 1'b0, 1'b0, 32'h0);
        check("second_pc_out", pc_out, 32'h4);
        idle_step();
        check("third_addr", imem_addr, 32'h8);

        // Redirect while waiting at 0x8; the late ack must be discarded.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        idle_step();
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check("kill_no_valid", {31'b0, instr_valid}, 32'd0);
        check("kill_refetch_addr", imem_addr, 32'h100);

        // Stall holds the instruction for three cycles.
        step(1'b1, 32'h8D09_0004, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
            check("stall_opcode", {26'b0, opcode}, 32'h23);
            check("stall_imm16",  {16'b0, imm16},  32'h0004);
            check("stall_req",    {31'b0, imem_req}, 32'd0);
            check("stall_pc_out", pc_out, 32'h100);
        end

        // Redirect during VALID+stall drops the instruction, low bits ignored.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h203);
        check("redir_valid", {31'b0, instr_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h200);

        // Redirect to the top word (same-cycle ack discarded), then wrap.
        step(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hFFFF_FFFE);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 32'h2002_0001, 1'b0, 1'b0, 32'h0);
        check("top_pc_out", pc_out, 32'hFFFF_FFFC);
        idle_step();
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Asynchronous reset while a request is outstanding.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req",   {31'b0, imem_req}, 32'd0);
        check("async_valid", {31'b0, instr_valid}, 32'd0);
        check("async_pc_out", pc_out, 32'd0);
        model_reset();
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        check("restart_req",  {31'b0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        step(1'b1, 32'h2108_0003, 1'b0, 1'b0, 32'h0);
        check("restart_pc_out", pc_out, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          a, st, rdir;
            logic [31:0] w, rpc;
            a    = ($urandom_range(0, 9) < 6);
            st   = ($urandom_range(0, 9) < 3);
            rdir = ($urandom_range(0, 99) < 8);
            w    = $urandom;
            rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(a, w, st, rdir, rpc);
        end
        compare_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
